// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: load-use stall, taken-branch flush, halt drain/freeze.
// Latency: stall/flush/halt controls are combinational, so they act in the same cycle as the trigger.
// Backpressure: stalls by dropping pc_en/ifid_en and inserting a bubble into ID/EX.
module pipe_ctrl #(
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      ir_id,
    input  logic [31:0]      ir_ex,
    input  logic             hlt_id,
    input  logic             br_taken,
    input  logic             resume,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             halted,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t     cur;
    logic [1:0] drain_cnt;

    logic [5:0] op_id;
    logic [5:0] op_ex;
    logic [4:0] rs_id;
    logic [4:0] rt_id;
    logic [4:0] rt_ex;
    logic       rt_is_src;
    logic       lu;

    assign op_id = ir_id[31:26];
    assign rs_id = ir_id[25:21];
    assign rt_id = ir_id[20:16];
    assign op_ex = ir_ex[31:26];
    assign rt_ex = ir_ex[20:16];

    // Opcodes whose rt field is read as a source: R-type, sw, beq, bne.
    assign rt_is_src = (op_id == 6'h00) || (op_id == 6'h2B) ||
                       (op_id == 6'h04) || (op_id == 6'h05);

    // A lw in EX whose destination is read by the instruction in ID.
    assign lu = (op_ex == 6'h23) && (rt_ex != 5'd0) &&
                ((rt_ex == rs_id) || ((rt_ex == rt_id) && rt_is_src)) &&
                !hlt_id;

    assign state = cur;

    // Stage enables and flushes, decoded from the current state and this cycle's inputs.
    always_comb begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        ifid_flush = 1'b0;
        idex_flush = 1'b1;
        halted     = 1'b0;
        case (cur)
            RUN: begin
                if (br_taken) begin
                    // Wrong-path instructions in IF/ID and ID/EX are squashed.
                    pc_en      = 1'b1;
                    ifid_en    = 1'b1;
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                end else if (hlt_id) begin
                    // Freeze fetch but let the halt itself advance into EX.
                    idex_flush = 1'b0;
                end else if (lu) begin
                    idex_flush = 1'b1;
                end else begin
                    pc_en      = 1'b1;
                    ifid_en    = 1'b1;
                    idex_flush = 1'b0;
                end
            end
            DRAIN: begin
                idex_flush = 1'b1;
            end
            HALTED: begin
                halted = 1'b1;
                if (resume) begin
                    // Replace the stale halt in IF/ID with a NOP; PC stays put one more cycle.
                    ifid_en    = 1'b1;
                    ifid_flush = 1'b1;
                end
            end
            default: begin
                // Unreachable encoding: hold the front end and bubble until recovered to RUN.
                idex_flush = 1'b1;
            end
        endcase
    end

    // State machine, drain countdown and saturating load-use stall counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur       <= RUN;
            drain_cnt <= 2'd0;
            stall_cnt <= '0;
        end else begin
            case (cur)
                RUN: begin
                    if (!br_taken && hlt_id) begin
                        cur       <= DRAIN;
                        drain_cnt <= 2'(DRAIN_CYCLES - 1);
                    end
                    if (!br_taken && lu && (stall_cnt != {CNT_W{1'b1}})) begin
                        stall_cnt <= stall_cnt + 1'b1;
                    end
                end
                DRAIN: begin
                    if (drain_cnt == 2'd0) begin
                        cur <= HALTED;
                    end else begin
                        drain_cnt <= drain_cnt - 2'd1;
                    end
                end
                HALTED: begin
                    if (resume) begin
                        cur <= RUN;
                    end
                end
                default: begin
                    cur <= RUN;
                end
            endcase
        end
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline sequencing controller for the 5-stage MIPS32 core (IF, ID, EX, MEM, WB). It inspects the instructions held in the IF/ID and ID/EX pipeline registers and generates the PC enable, IF/ID enable and flush controls that drive the fetch and decode stages:

- one-bubble stall on load-use hazards;
- flush on taken branches;
- pipeline drain and freeze on the decode stage's halt flag.

It also keeps a saturating stall counter for performance debug.

## Interface

Parameters:
- DRAIN_CYCLES, default 3: cycles spent in DRAIN after the halt leaves ID, covering the halt passing through EX, MEM and WB.
- CNT_W, default 16: width of `stall_cnt`.

Ports:
- clk  in  1  single clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- ir_id  in  32  instruction in IF/ID, being decoded.
- ir_ex  in  32  instruction in ID/EX, executing.
- hlt_id  in  1  decode stage flags the instruction in ID as halt.
- br_taken  in  1  EX resolved a taken branch this cycle.
- resume  in  1  leave HALTED.
- pc_en  out  1  PC register load enable.
- ifid_en  out  1  IF/ID register load enable.
- ifid_flush  out  1  load a NOP (32'h0) into IF/ID.
- idex_flush  out  1  load a bubble into ID/EX.
- halted  out  1  pipeline frozen.
- state  out  2  current state: 0 RUN, 1 DRAIN, 2 HALTED.
- stall_cnt  out  CNT_W  count of load-use stall cycles, saturating.

## Operation

Field decode (MIPS32): op=[31:26], rs=[25:21], rt=[20:16].

Load-use hazard (`lu`) is asserted when all of the following hold:
- op_ex==6'h23 (lw) and rt_ex!=0;
- and either rt_ex==rs_id, or rt_ex==rt_id with op_id in {6'h00, 6'h2B, 6'h04, 6'h05} (R-type, sw, beq, bne);
- and hlt_id==0.

State register and drain counter:
- State is a 2-bit register. The drain counter is a 2-bit register.
- The outputs `pc_en`, `ifid_en`, `ifid_flush`, `idex_flush` and `halted` are combinational from state and inputs.

RUN, with priority br_taken > hlt_id > lu:
- br_taken=1: pc_en=1, ifid_en=1, ifid_flush=1, idex_flush=1. Stay in RUN. A simultaneous hlt_id is discarded, because the halt is on the wrong path.
- hlt_id=1: pc_en=0, ifid_en=0. The halt is allowed into ID/EX (idex_flush=0). Next state is DRAIN, and the counter is loaded with DRAIN_CYCLES-1.
- lu=1: pc_en=0, ifid_en=0, idex_flush=1. Stay in RUN; the hazard clears the next cycle because EX then holds a bubble.
- Otherwise: pc_en=1, ifid_en=1, no flushes.

DRAIN:
- Outputs: pc_en=0, ifid_en=0, idex_flush=1.
- br_taken and lu are ignored.
- The counter decrements each cycle. When the counter is 0, the next state is HALTED.

HALTED:
- Outputs: pc_en=0, ifid_en=0, idex_flush=1, halted=1.
- resume=1: ifid_flush=1 and ifid_en=1, which discards the stale halt in IF/ID. The PC stays held this cycle. Next state is RUN.
- PC is held throughout DRAIN and HALTED, so fetch restarts at the instruction after the halt.

stall_cnt:
- Increments in every RUN cycle with lu=1 and br_taken=0.
- Saturates at all-ones.
- Cleared only by rst.

Illegal state value 3: next state is RUN.

## Timing

- Reset (asynchronous): state=RUN, drain counter=0, stall_cnt=0.
- Output values during and after reset, with inputs at 0: pc_en=1, ifid_en=1, ifid_flush=0, idex_flush=0, halted=0.
- Stall, flush and halt controls are zero-latency: they are asserted in the same cycle as the triggering input.
- Halt timeline, with hlt_id seen at cycle T:
  - T+1..T+3: DRAIN, with the halt in EX, then MEM, then WB.
  - T+4: HALTED, halted=1.
  - pc_en=0 from T onward.
- Resume: with resume high at cycle R, state is RUN at R+1 and pc_en=1 from R+1.
- rst in any state returns immediately to RUN with cleared counters. An in-progress drain is abandoned.
- resume outside HALTED is ignored.

## Test plan

- Reset: pulse rst mid-cycle → immediately state=0, pc_en=1, ifid_en=1, ifid_flush=0, idex_flush=0, halted=0, stall_cnt=0.
- Load-use: ir_ex=32'h8C120004 (lw $18), ir_id=32'h02528020 (add $16,$18,$18) → pc_en=0, ifid_en=0, idex_flush=1; stall_cnt goes from 0 to 1 at the next edge.
- No-hazard cases:
  - ir_ex=32'h8C000004 (lw $0) → no stall.
  - ir_id=32'h20100005 (addi, rt not a source) with ir_ex=32'h8C100000 → no stall.
- Branch: br_taken=1 together with a load-use pattern → pc_en=1, ifid_flush=1, idex_flush=1, stall_cnt unchanged.
- Halt sequence: hlt_id=1 at T → state=1 at T+1..T+3, state=2 and halted=1 at T+4. Then resume=1 → ifid_flush=1 that cycle, state=0 next cycle.
- Halt corner cases:
  - hlt_id=1 with br_taken=1 → stays in RUN with both flushes asserted.
  - rst asserted at T+2 of a drain → state=0, halted=0 without waiting for a clock edge.
